// File: rtl/keypad_pkg.sv
// Shared types and constants for the scanned 4x4 keypad reader.
package keypad_pkg;
   localparam int         KEY_W     = 4;
   localparam logic [3:0] NO_KEY    = 4'b1111;
   localparam logic [3:0] COL_RESET = 4'b1110;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction
endpackage

// File: rtl/keypad_onehot_index.sv
// Decodes an active-low 4-bit vector into {exactly-one-low flag, position of the low bit}.
module keypad_onehot_index
   import keypad_pkg::*;
(
   input  logic [3:0] vec_n,
   output logic       single,
   output logic [1:0] index
);
   always_comb begin
      single = 1'b1;
      index  = 2'd0;
      case (vec_n)
         4'b1110: index = 2'd0;
         4'b1101: index = 2'd1;
         4'b1011: index = 2'd2;
         4'b0111: index = 2'd3;
         default: single = 1'b0;
      endcase
   end
endmodule

// File: rtl/keypad_scan.sv
// Scans a 4x4 active-low keypad, debounces one key, emits a registered code with a 1-cycle valid.
// Press accepted DEBOUNCE-1 edges after the detecting scan sample; all outputs registered.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int DWELL    = 2,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);
   localparam int             DW         = $clog2(DWELL);
   localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
   localparam logic [3:0]     DEB_N      = 4'(DEBOUNCE);

   state_t           state_q, state_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       pat_q, pat_d;
   logic [KEY_W-1:0] code_q, code_d;
   logic [3:0]       col_q, col_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;

   logic       row_single, col_single;
   logic [1:0] row_idx, col_idx;
   logic       dwell_end, row_match, cnt_last;

   keypad_onehot_index u_row_idx (.vec_n(row),   .single(row_single), .index(row_idx));
   keypad_onehot_index u_col_idx (.vec_n(col_q), .single(col_single), .index(col_idx));

   assign dwell_end = (dwell_q == DWELL_LAST);
   assign row_match = (row == pat_q);
   assign cnt_last  = ((cnt_q + 4'd1) == DEB_N);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_SCAN;
         dwell_q     <= '0;
         cnt_q       <= 4'd0;
         pat_q       <= NO_KEY;
         code_q      <= '0;
         col_q       <= COL_RESET;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dwell_q     <= dwell_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         code_q      <= code_d;
         col_q       <= col_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SCAN:     if (dwell_end && row_single && col_single) state_d = ST_DEBOUNCE;
         ST_DEBOUNCE: if (!row_match) state_d = ST_SCAN;
                      else if (cnt_last) state_d = ST_HELD;
         ST_HELD:     if (!row_match) state_d = ST_RELEASE;
         ST_RELEASE:  if (row_match) state_d = ST_HELD;
                      else if (row == NO_KEY && cnt_last) state_d = ST_SCAN;
         default:     state_d = ST_SCAN;
      endcase
   end

   always_comb begin
      dwell_d     = dwell_q;
      cnt_d       = cnt_q;
      pat_d       = pat_q;
      code_d      = code_q;
      col_d       = col_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      case (state_q)
         ST_SCAN: begin
            if (dwell_end) begin
               dwell_d = '0;
               if (row_single && col_single) begin
                  pat_d  = row;
                  code_d = {row_idx, col_idx};
                  cnt_d  = 4'd1;
               end else begin
                  col_d = rotl(col_q);
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (!row_match) begin
               col_d   = rotl(col_q);
               dwell_d = '0;
               cnt_d   = 4'd0;
            end else if (cnt_last) begin
               key_d       = code_q;
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
               cnt_d       = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HELD: begin
            if (!row_match) cnt_d = 4'd1;
         end
         ST_RELEASE: begin
            // Only an unbroken run of idle samples completes a release.
            if (row_match) begin
               cnt_d = 4'd0;
            end else if (row == NO_KEY) begin
               if (cnt_last) begin
                  key_held_d = 1'b0;
                  col_d      = rotl(col_q);
                  dwell_d    = '0;
                  cnt_d      = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = 4'd0;
            end
         end
         default: ;
      endcase
   end

   assign col       = col_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad matrix model and a key-code scoreboard.
module tb_keypad_scan;
   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  row, col, key;
   logic        key_valid, key_held;

   logic [15:0] pressed;
   logic        ovr_en;
   logic [3:0]  ovr_row;
   logic [3:0]  exp_q[$];
   logic [3:0]  c;
   logic [3:0]  e;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] kp_row(input logic [3:0] cs, input logic [15:0] p);
      logic [3:0] r;
      r = 4'hF;
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++)
            if (p[rr*4+cc] && !cs[cc]) r[rr] = 1'b0;
      return r;
   endfunction

   assign row = ovr_en ? ovr_row : kp_row(col, pressed);

   keypad_scan #(.DWELL(2), .DEBOUNCE(4)) dut (
      .clk(clk), .clr(clr), .row(row), .col(col),
      .key(key), .key_valid(key_valid), .key_held(key_held)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n;
      n = 0;
      while (key_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (key_valid === 1'b1)
      else begin
         failures++;
         $error("FAIL %s observed=no key_valid expected=key_valid within %0d cycles", tag, budget);
      end
   endtask

   task automatic wait_held_low(input int budget, input string tag);
      int n;
      n = 0;
      while (key_held !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (key_held === 1'b0)
      else begin
         failures++;
         $error("FAIL %s observed=key_held 1 expected=key_held 0 within %0d cycles", tag, budget);
      end
   endtask

   // Scoreboard: every key_valid must match the oldest outstanding expected code.
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0)
         else begin
            failures++;
            $error("FAIL unexpected_valid observed=key %h expected=no key_valid", key);
         end
         if (exp_q.size() != 0) chk("sb_key", key, exp_q.pop_front());
      end
   end

   initial begin
      clr     = 1'b1;
      pressed = 16'h0000;
      ovr_en  = 1'b0;
      ovr_row = 4'hF;

      @(negedge clk);
      chk("rst_col", col, 4'b1110);
      chk("rst_key", key, 4'h0);
      chk("rst_valid", {3'b0, key_valid}, 4'h0);
      chk("rst_held", {3'b0, key_held}, 4'h0);

      // Idle scan: each column held two cycles, order 0,1,2,3.
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         e = 4'b1111 ^ (4'b0001 << ((i / 2) % 4));
         chk("idle_col", col, e);
         @(negedge clk);
      end
      chk("idle_key", key, 4'h0);

      // Key row 2 / col 1: detected when col1 is sampled, accepted three edges later.
      pressed = 16'h0200;
      exp_q.push_back(4'h9);
      repeat (6) @(negedge clk);
      chk("press_pre_valid", {3'b0, key_valid}, 4'h0);
      chk("press_pre_held", {3'b0, key_held}, 4'h0);
      @(negedge clk);
      chk("press_valid", {3'b0, key_valid}, 4'h1);
      chk("press_key", key, 4'h9);
      chk("press_held", {3'b0, key_held}, 4'h1);
      @(negedge clk);
      chk("press_valid_1cyc", {3'b0, key_valid}, 4'h0);
      chk("press_col_frozen", col, 4'b1101);
      repeat (5) @(negedge clk);
      chk("hold_col_frozen", col, 4'b1101);
      chk("hold_held", {3'b0, key_held}, 4'h1);

      // Release with one bounce back to the key, then four idle samples.
      ovr_en  = 1'b1;
      ovr_row = 4'b1111;
      @(negedge clk);
      chk("rel_b1_held", {3'b0, key_held}, 4'h1);
      ovr_row = 4'b1011;
      @(negedge clk);
      chk("rel_b2_held", {3'b0, key_held}, 4'h1);
      ovr_row = 4'b1111;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("rel_run_held", {3'b0, key_held}, (k < 4) ? 4'h1 : 4'h0);
      end
      chk("rel_col_next", col, 4'b1011);
      chk("rel_key_sticky", key, 4'h9);

      // Bounce during debounce: abandon and resume at the following column.
      ovr_en = 1'b0;
      repeat (8) @(negedge clk);
      ovr_en  = 1'b1;
      ovr_row = 4'b1111;
      @(negedge clk);
      chk("deb_abandon_col", col, 4'b1011);
      chk("deb_abandon_valid", {3'b0, key_valid}, 4'h0);
      chk("deb_abandon_held", {3'b0, key_held}, 4'h0);
      ovr_en = 1'b0;
      exp_q.push_back(4'h9);
      wait_valid(40, "stable_press");
      chk("stable_col", col, 4'b1101);

      pressed = 16'h0000;
      wait_held_low(20, "stable_release");
      chk("stable_rel_col", col, 4'b1011);
      chk("stable_rel_key", key, 4'h9);

      // Ghosting: two rows low never captures, scanning continues.
      ovr_en  = 1'b1;
      ovr_row = 4'b1001;
      c = col;
      repeat (2) @(negedge clk);
      chk("ghost_rot", col, {c[2:0], c[3]});
      repeat (6) @(negedge clk);
      chk("ghost_period", col, c);
      chk("ghost_held", {3'b0, key_held}, 4'h0);
      ovr_en = 1'b0;

      // Key 0 held, key 5 added: ignored until key 0 is fully released.
      pressed = 16'h0001;
      exp_q.push_back(4'h0);
      wait_valid(40, "key0");
      pressed = 16'h0021;
      repeat (12) @(negedge clk);
      chk("rollover_col", col, 4'b1110);
      chk("rollover_held", {3'b0, key_held}, 4'h1);
      chk("rollover_key", key, 4'h0);
      pressed = 16'h0020;
      exp_q.push_back(4'h5);
      wait_held_low(20, "key0_release");
      chk("key0_rel_col", col, 4'b1101);
      wait_valid(20, "key5");

      // Asynchronous clear while key_valid is high.
      #2 clr = 1'b1;
      #1;
      chk("clr_col", col, 4'b1110);
      chk("clr_key", key, 4'h0);
      chk("clr_valid", {3'b0, key_valid}, 4'h0);
      chk("clr_held", {3'b0, key_held}, 4'h0);
      @(negedge clk);
      clr = 1'b0;
      exp_q.push_back(4'h5);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         chk("post_clr_valid", {3'b0, key_valid}, (i == 7) ? 4'h1 : 4'h0);
      end
      chk("post_clr_key", key, 4'h5);
      chk("post_clr_held", {3'b0, key_held}, 4'h1);

      @(negedge clk);
      chk("sb_empty", 4'(exp_q.size()), 4'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
